// File: rtl/adma_descriptor_table.sv
// rtl/adma_descriptor_table.sv - ADMA descriptor table with hardware link/nop chain walker
module adma_descriptor_table #(
   parameter int MAX_HOPS = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tbl_wr_en,
   input  logic [5:0]  tbl_wr_index,
   input  logic [95:0] tbl_wr_data,
   input  logic        fetch_req,
   input  logic [5:0]  fetch_index,
   output logic        fetch_ack,
   output logic        busy,
   output logic [63:0] data_address,
   output logic [15:0] length,
   output logic [5:0]  descriptor_index,
   output logic        act1,
   output logic        act2,
   output logic        END,
   output logic        valid,
   output logic        desc_error
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_READ = 3'd1;
   localparam logic [2:0] S_EVAL = 3'd2;
   localparam logic [2:0] S_DONE = 3'd3;
   localparam logic [2:0] S_ERR  = 3'd4;

   localparam logic [5:0] HOP_LIMIT = 6'(MAX_HOPS);

   logic [95:0] desc_mem [0:63];
   logic [95:0] entry_q;
   logic [2:0]  state;
   logic [5:0]  cur_idx;
   logic [5:0]  hops;

   // Decoded fields of the entry under evaluation
   logic       e_valid;
   logic       e_end;
   logic [1:0] e_action;
   logic [5:0] e_link_idx;

   assign e_valid    = entry_q[1];
   assign e_end      = entry_q[2];
   assign e_action   = {entry_q[3], entry_q[4]};
   assign e_link_idx = entry_q[37:32];

   assign busy = (state != S_IDLE);

   // Host writes to the table; storage is deliberately not reset so contents survive reset
   always_ff @(posedge clk) begin
      if (tbl_wr_en)
         desc_mem[tbl_wr_index] <= tbl_wr_data;
   end

   // Chain-walk FSM and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= S_IDLE;
         cur_idx          <= 6'd0;
         hops             <= 6'd0;
         entry_q          <= 96'd0;
         fetch_ack        <= 1'b0;
         data_address     <= 64'd0;
         length           <= 16'd0;
         descriptor_index <= 6'd0;
         act1             <= 1'b0;
         act2             <= 1'b0;
         END              <= 1'b0;
         valid            <= 1'b0;
         desc_error       <= 1'b0;
      end else begin
         fetch_ack <= 1'b0;
         case (state)
            S_IDLE: begin
               if (fetch_req) begin
                  cur_idx    <= fetch_index;
                  hops       <= 6'd0;
                  desc_error <= 1'b0;
                  state      <= S_READ;
               end
            end
            S_READ: begin
               // A same-cycle host write to this entry lands after this read (old data returned)
               entry_q <= desc_mem[cur_idx];
               state   <= S_EVAL;
            end
            S_EVAL: begin
               if (!e_valid) begin
                  state <= S_ERR;
               end else if (e_end || e_action == 2'b10) begin
                  state <= S_DONE;
               end else if (hops == HOP_LIMIT) begin
                  // MAX_HOPS hops already taken; another one means the chain is runaway
                  state <= S_ERR;
               end else begin
                  hops    <= hops + 6'd1;
                  cur_idx <= (e_action == 2'b11) ? e_link_idx : cur_idx + 6'd1;
                  state   <= S_READ;
               end
            end
            S_DONE, S_ERR: begin
               data_address     <= entry_q[95:32];
               length           <= entry_q[31:16];
               act1             <= entry_q[4];
               act2             <= entry_q[3];
               END              <= entry_q[2];
               descriptor_index <= cur_idx;
               valid            <= (state == S_DONE) ? entry_q[1] : 1'b0;
               desc_error       <= (state == S_ERR);
               fetch_ack        <= 1'b1;
               state            <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adma_descriptor_table.sv
// tb/tb_adma_descriptor_table.sv - self-checking bench for adma_descriptor_table
module tb_adma_descriptor_table;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        tbl_wr_en = 1'b0;
   logic [5:0]  tbl_wr_index = 6'd0;
   logic [95:0] tbl_wr_data = 96'd0;
   logic        fetch_req = 1'b0;
   logic [5:0]  fetch_index = 6'd0;
   logic        fetch_ack;
   logic        busy;
   logic [63:0] data_address;
   logic [15:0] length;
   logic [5:0]  descriptor_index;
   logic        act1, act2, END, valid, desc_error;

   int checks = 0;
   int errors = 0;

   logic [95:0] ref_mem [0:63];

   logic [90:0] obs_vec;
   int          obs_cyc;
   logic        obs_ack;

   adma_descriptor_table #(.MAX_HOPS(8)) dut (
      .clk(clk), .reset(reset),
      .tbl_wr_en(tbl_wr_en), .tbl_wr_index(tbl_wr_index), .tbl_wr_data(tbl_wr_data),
      .fetch_req(fetch_req), .fetch_index(fetch_index),
      .fetch_ack(fetch_ack), .busy(busy),
      .data_address(data_address), .length(length), .descriptor_index(descriptor_index),
      .act1(act1), .act2(act2), .END(END), .valid(valid), .desc_error(desc_error)
   );

   always #5 clk = ~clk;

   function automatic logic [95:0] mk(input logic [63:0] addr, input logic [15:0] len,
                                      input logic a2, input logic a1, input logic e, input logic v);
      return {addr, len, 11'd0, a1, a2, e, v, 1'b0};
   endfunction

   // Walk the chain the way the DMA contract describes it; returns
   // {desc_error, valid, END, act2, act1, index, length, address}
   function automatic logic [90:0] model_fetch(input logic [5:0] start, output int cyc);
      logic [5:0]  idx;
      int          hops;
      logic [95:0] e;
      logic        is_tran, is_link;
      idx  = start;
      hops = 0;
      for (int guard = 0; guard < 100; guard++) begin
         e       = ref_mem[idx];
         is_tran = e[3] && !e[4];
         is_link = e[3] && e[4];
         cyc     = 3 + 2 * hops;
         if (!e[1])
            return {1'b1, 1'b0, e[2], e[3], e[4], idx, e[31:16], e[95:32]};
         if (e[2] || is_tran)
            return {1'b0, 1'b1, e[2], e[3], e[4], idx, e[31:16], e[95:32]};
         if (hops == 8)
            return {1'b1, 1'b0, e[2], e[3], e[4], idx, e[31:16], e[95:32]};
         hops = hops + 1;
         idx  = is_link ? e[37:32] : idx + 6'd1;
      end
      cyc = -1;
      return '0;
   endfunction

   task automatic write_entry(input logic [5:0] idx, input logic [95:0] data);
      @(negedge clk);
      tbl_wr_en    = 1'b1;
      tbl_wr_index = idx;
      tbl_wr_data  = data;
      @(negedge clk);
      tbl_wr_en    = 1'b0;
      ref_mem[idx] = data;
   endtask

   task automatic wait_ack();
      obs_cyc = 0;
      while (!fetch_ack && obs_cyc < 100) begin
         @(negedge clk);
         obs_cyc++;
      end
      obs_ack = fetch_ack;
      obs_vec = {desc_error, valid, END, act2, act1, descriptor_index, length, data_address};
   endtask

   task automatic do_fetch(input logic [5:0] idx);
      @(negedge clk);
      fetch_req   = 1'b1;
      fetch_index = idx;
      @(negedge clk);
      fetch_req   = 1'b0;
      wait_ack();
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({fetch_ack, busy, desc_error, data_address, length, descriptor_index,
           act1, act2, END, valid} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got ack=%b busy=%b err=%b addr=%h len=%h idx=%0d",
                  fetch_ack, busy, desc_error, data_address, length, descriptor_index);
      end
      reset = 1'b0;
      for (int i = 0; i < 64; i++)
         write_entry(6'(i), mk({$urandom, $urandom}, 16'($urandom), 1'b1, 1'b0, 1'b0, 1'b1));
   endtask

   task automatic test_tran();
      logic [90:0] exp;
      int          ecyc;
      write_entry(6'd5, mk(64'h1000, 16'h0200, 1'b1, 1'b0, 1'b0, 1'b1));
      do_fetch(6'd5);
      exp = model_fetch(6'd5, ecyc);
      checks++;
      if (!obs_ack || obs_cyc !== 3 || obs_vec !== exp) begin
         errors++;
         $display("FAIL tran: ack=%b cyc=%0d got %h need cyc 3 %h", obs_ack, obs_cyc, obs_vec, exp);
      end
      checks++;
      if (data_address !== 64'h1000 || length !== 16'h0200 || descriptor_index !== 6'd5 ||
          act2 !== 1'b1 || act1 !== 1'b0 || desc_error !== 1'b0) begin
         errors++;
         $display("FAIL tran_fields: addr=%h len=%h idx=%0d a2=%b a1=%b err=%b need 1000 0200 5 1 0 0",
                  data_address, length, descriptor_index, act2, act1, desc_error);
      end
      @(negedge clk);
      checks++;
      if (fetch_ack !== 1'b0 || busy !== 1'b0 || data_address !== 64'h1000) begin
         errors++;
         $display("FAIL ack_pulse: ack=%b busy=%b addr=%h need 0 0 1000", fetch_ack, busy, data_address);
      end
   endtask

   task automatic test_link();
      logic [90:0] exp;
      int          ecyc;
      write_entry(6'd2, mk(64'hFFFF_0000_0000_0009, 16'h0010, 1'b1, 1'b1, 1'b0, 1'b1));
      write_entry(6'd9, mk(64'h2000, 16'h0040, 1'b1, 1'b0, 1'b1, 1'b1));
      do_fetch(6'd2);
      exp = model_fetch(6'd2, ecyc);
      checks++;
      if (!obs_ack || obs_cyc !== 5 || obs_vec !== exp || descriptor_index !== 6'd9 || END !== 1'b1) begin
         errors++;
         $display("FAIL link: ack=%b cyc=%0d got %h need cyc 5 %h", obs_ack, obs_cyc, obs_vec, exp);
      end
   endtask

   task automatic test_wrap();
      logic [90:0] exp;
      int          ecyc;
      write_entry(6'd63, mk(64'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1));
      write_entry(6'd0, mk(64'h3000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1));
      do_fetch(6'd63);
      exp = model_fetch(6'd63, ecyc);
      checks++;
      if (!obs_ack || obs_cyc !== 5 || obs_vec !== exp || descriptor_index !== 6'd0) begin
         errors++;
         $display("FAIL wrap: ack=%b cyc=%0d got %h need cyc 5 %h", obs_ack, obs_cyc, obs_vec, exp);
      end
   endtask

   task automatic test_invalid();
      logic [90:0] exp;
      int          ecyc;
      write_entry(6'd7, mk(64'h7777, 16'h0077, 1'b1, 1'b0, 1'b0, 1'b0));
      do_fetch(6'd7);
      exp = model_fetch(6'd7, ecyc);
      checks++;
      if (!obs_ack || obs_cyc !== 3 || obs_vec !== exp || desc_error !== 1'b1 || valid !== 1'b0 ||
          descriptor_index !== 6'd7) begin
         errors++;
         $display("FAIL invalid: ack=%b cyc=%0d got %h need cyc 3 %h", obs_ack, obs_cyc, obs_vec, exp);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (desc_error !== 1'b1) begin
         errors++;
         $display("FAIL err_hold: desc_error=%b need 1", desc_error);
      end
      do_fetch(6'd5);
      exp = model_fetch(6'd5, ecyc);
      checks++;
      if (!obs_ack || obs_vec !== exp || desc_error !== 1'b0) begin
         errors++;
         $display("FAIL err_clear: err=%b got %h need %h", desc_error, obs_vec, exp);
      end
   endtask

   task automatic test_hop_limit();
      logic [90:0] exp;
      int          ecyc;
      write_entry(6'd10, mk(64'h0000_0000_0000_000A, 16'h0101, 1'b1, 1'b1, 1'b0, 1'b1));
      do_fetch(6'd10);
      exp = model_fetch(6'd10, ecyc);
      checks++;
      if (!obs_ack || obs_cyc !== 19 || obs_cyc !== ecyc || obs_vec !== exp || desc_error !== 1'b1 ||
          descriptor_index !== 6'd10) begin
         errors++;
         $display("FAIL hop_limit: ack=%b cyc=%0d got %h need cyc 19 %h", obs_ack, obs_cyc, obs_vec, exp);
      end
   endtask

   task automatic test_ignore_req();
      logic [90:0] exp;
      int          ecyc;
      @(negedge clk);
      fetch_req   = 1'b1;
      fetch_index = 6'd5;
      @(negedge clk);
      fetch_index = 6'd2;
      @(negedge clk);
      @(negedge clk);
      fetch_req = 1'b0;
      obs_cyc = 2;
      while (!fetch_ack && obs_cyc < 100) begin
         @(negedge clk);
         obs_cyc++;
      end
      exp = model_fetch(6'd5, ecyc);
      checks++;
      if (!fetch_ack || obs_cyc !== 3 ||
          {desc_error, valid, END, act2, act1, descriptor_index, length, data_address} !== exp) begin
         errors++;
         $display("FAIL busy_ignore: ack=%b cyc=%0d idx=%0d need cyc 3 idx 5", fetch_ack, obs_cyc, descriptor_index);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_ignore_idle: busy=%b need 0", busy);
      end
   endtask

   task automatic test_same_cycle_write();
      logic [90:0] exp;
      int          ecyc;
      logic [95:0] newd;
      write_entry(6'd20, mk(64'hAAAA, 16'h0A0A, 1'b1, 1'b0, 1'b0, 1'b1));
      newd = mk(64'hBBBB, 16'h0B0B, 1'b1, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      fetch_req   = 1'b1;
      fetch_index = 6'd20;
      @(negedge clk);
      fetch_req    = 1'b0;
      tbl_wr_en    = 1'b1;
      tbl_wr_index = 6'd20;
      tbl_wr_data  = newd;
      @(negedge clk);
      tbl_wr_en = 1'b0;
      obs_cyc = 1;
      while (!fetch_ack && obs_cyc < 100) begin
         @(negedge clk);
         obs_cyc++;
      end
      exp = model_fetch(6'd20, ecyc);
      checks++;
      if (!fetch_ack || data_address !== 64'hAAAA ||
          {desc_error, valid, END, act2, act1, descriptor_index, length, data_address} !== exp) begin
         errors++;
         $display("FAIL rw_same_cycle: ack=%b addr=%h need old AAAA", fetch_ack, data_address);
      end
      ref_mem[20] = newd;
      do_fetch(6'd20);
      exp = model_fetch(6'd20, ecyc);
      checks++;
      if (!obs_ack || obs_vec !== exp) begin
         errors++;
         $display("FAIL rw_new_data: got %h need %h", obs_vec, exp);
      end
   endtask

   task automatic test_reset_mid_fetch();
      logic [90:0] exp;
      int          ecyc;
      int          seen;
      @(negedge clk);
      fetch_req   = 1'b1;
      fetch_index = 6'd2;
      @(negedge clk);
      fetch_req = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if ({fetch_ack, busy, desc_error, data_address, length, descriptor_index,
           act1, act2, END, valid} !== '0) begin
         errors++;
         $display("FAIL reset_mid: ack=%b busy=%b err=%b addr=%h idx=%0d need all 0",
                  fetch_ack, busy, desc_error, data_address, descriptor_index);
      end
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (fetch_ack || busy) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL reset_no_ack: saw %0d ack/busy cycles need 0", seen);
      end
      do_fetch(6'd2);
      exp = model_fetch(6'd2, ecyc);
      checks++;
      if (!obs_ack || obs_cyc !== 5 || obs_vec !== exp) begin
         errors++;
         $display("FAIL reset_refetch: ack=%b cyc=%0d got %h need %h", obs_ack, obs_cyc, obs_vec, exp);
      end
   endtask

   task automatic test_random();
      logic [90:0] exp;
      int          ecyc;
      logic [5:0]  s;
      for (int i = 0; i < 64; i++)
         write_entry(6'(i), mk({$urandom, $urandom}, 16'($urandom), 1'($urandom), 1'($urandom),
                               ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) != 0)));
      for (int n = 0; n < 40; n++) begin
         s = 6'($urandom_range(0, 63));
         do_fetch(s);
         exp = model_fetch(s, ecyc);
         checks++;
         if (!obs_ack || obs_cyc !== ecyc || obs_vec !== exp) begin
            errors++;
            $display("FAIL random[%0d] start %0d: ack=%b cyc=%0d got %h need cyc %0d %h",
                     n, s, obs_ack, obs_cyc, obs_vec, ecyc, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_tran();
      test_link();
      test_wrap();
      test_invalid();
      test_hop_limit();
      test_ignore_req();
      test_same_cycle_write();
      test_reset_mid_fetch();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
